// File: rtl/wishbone_cmd_master.sv
// Wishbone classic single-transfer master fed by a valid/ready command port.
// Handles slave retry (bounded re-issue) and a per-attempt wait timeout.
module wishbone_cmd_master #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = 4,
    parameter int MAX_RETRIES  = 3,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk_i,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [DATA_WIDTH-1:0]   cmd_dat,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_dat,
    output logic [1:0]              rsp_status,
    output logic                    cyc_o,
    output logic                    stb_o,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic [SELECT_WIDTH-1:0] sel_o,
    output logic [1:0]              tgd_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic                    ack_i,
    input  logic                    err_i,
    input  logic                    rty_i,
    input  logic [1:0]              tgd_i,
    output logic [1:0]              state_dbg
);

    // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready
    // (cmd_ready is high only in IDLE); rsp_valid is a one-cycle pulse with no back-pressure.

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ERR     = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_RETRY   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        BACKOFF = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [1:0]      status_d;
    logic            latch_cmd;
    logic            capture;
    logic            unused_tgd;

    assign unused_tgd = ^tgd_i;
    assign tgd_o      = 2'h0;
    assign state_dbg  = state_q;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            retry_q    <= '0;
            we_o       <= 1'b0;
            adr_o      <= '0;
            dat_o      <= '0;
            sel_o      <= '0;
            rsp_dat    <= '0;
            rsp_status <= ST_OK;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            rsp_status <= status_d;
            if (latch_cmd) begin
                we_o  <= cmd_we;
                adr_o <= cmd_adr;
                dat_o <= cmd_dat;
                sel_o <= cmd_sel;
            end
            if (capture) begin
                rsp_dat <= dat_i;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        status_d  = rsp_status;
        latch_cmd = 1'b0;
        capture   = 1'b0;
        cmd_ready = 1'b0;
        cyc_o     = 1'b0;
        stb_o     = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    latch_cmd = 1'b1;
                    retry_d   = '0;
                    timer_d   = '0;
                    state_d   = BUS;
                end
            end
            BUS: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                // Simultaneous terminations resolve as ack > err > rty.
                if (ack_i) begin
                    capture  = 1'b1;
                    status_d = ST_OK;
                    state_d  = DONE;
                end else if (err_i) begin
                    status_d = ST_ERR;
                    state_d  = DONE;
                end else if (rty_i) begin
                    if (retry_q == RETRY_MAX) begin
                        status_d = ST_RETRY;
                        state_d  = DONE;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = BACKOFF;
                    end
                end else if ((TIMEOUT != 0) && (timer_q == TIMER_MAX)) begin
                    status_d = ST_TIMEOUT;
                    state_d  = DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            BACKOFF: begin
                timer_d = '0;
                state_d = BUS;
            end
            DONE: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wishbone_cmd_master.sv
// Self-checking bench for wishbone_cmd_master: scripted Wishbone slave plus a
// transaction-level model of attempts, status and response timing.
module tb_wishbone_cmd_master;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = 4;
    localparam int MAX_R = 2;
    localparam int TMO   = 5;

    localparam int K_ACK     = 0;
    localparam int K_ERR     = 1;
    localparam int K_RTY     = 2;
    localparam int K_ERR_RTY = 3;
    localparam int K_ALL     = 4;
    localparam int K_NONE    = 5;

    logic          clk_i = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid;
    logic [DW-1:0] rsp_dat;
    logic [1:0]    rsp_status;
    logic          cyc_o, stb_o, we_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [SW-1:0] sel_o;
    logic [1:0]    tgd_o;
    logic [DW-1:0] dat_i;
    logic          ack_i, err_i, rty_i;
    logic [1:0]    tgd_i;
    logic [1:0]    state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    // clock / reset
    always #5 clk_i = ~clk_i;

    wishbone_cmd_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SELECT_WIDTH(SW),
        .MAX_RETRIES(MAX_R), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk_i), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .sel_o(sel_o), .tgd_o(tgd_o), .dat_i(dat_i),
        .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .tgd_i(tgd_i),
        .state_dbg(state_dbg)
    );

    // Scripted slave: attempt k terminates with att_kind[k] after att_wait[k] wait cycles.
    int            att_kind[8];
    int            att_wait[8];
    int            att_idx = 0;
    int            att_cnt = 0;
    logic [DW-1:0] rd_data = '0;
    logic          hit;
    int            kind;

    always @(posedge clk_i) begin
        if (cmd_valid && cmd_ready) att_idx <= 0;
        else if (cyc_o && (ack_i || err_i || rty_i)) att_idx <= att_idx + 1;
        if (!cyc_o) att_cnt <= 0;
        else att_cnt <= att_cnt + 1;
    end

    always_comb begin
        kind  = att_kind[att_idx];
        hit   = cyc_o && (att_cnt == att_wait[att_idx]);
        ack_i = hit && (kind == K_ACK || kind == K_ALL);
        err_i = hit && (kind == K_ERR || kind == K_ERR_RTY || kind == K_ALL);
        rty_i = hit && (kind == K_RTY || kind == K_ERR_RTY || kind == K_ALL);
        dat_i = hit ? rd_data : ~rd_data;
        tgd_i = 2'b11;
    end

    // Scoreboard / reference model
    logic [DW-1:0] exp_q[$];
    int            exp_len_q[$];
    logic [1:0]    exp_status;
    int            exp_rsp_c;
    logic [DW-1:0] last_dat = '0;

    task automatic model_txn();
        int sum;
        sum = 0;
        exp_len_q.delete();
        exp_status = 2'd0;
        for (int k = 0; k <= MAX_R; k++) begin
            if (att_kind[k] == K_NONE || att_wait[k] > TMO) begin
                exp_len_q.push_back(TMO + 1);
                exp_status = 2'd2;
                break;
            end
            exp_len_q.push_back(att_wait[k] + 1);
            if (att_kind[k] == K_ACK || att_kind[k] == K_ALL) begin
                exp_status = 2'd0;
                break;
            end
            if (att_kind[k] == K_ERR || att_kind[k] == K_ERR_RTY) begin
                exp_status = 2'd1;
                break;
            end
            if (k == MAX_R) begin
                exp_status = 2'd3;
                break;
            end
        end
        foreach (exp_len_q[i]) sum += exp_len_q[i];
        // attempts, one-cycle gaps between them, then the response cycle
        exp_rsp_c = sum + exp_len_q.size();
        if (exp_status == 2'd0) last_dat = rd_data;
        exp_q.push_back(last_dat);
    endtask

    task automatic set_att(input int k, input int kd, input int w);
        att_kind[k] = kd;
        att_wait[k] = w;
    endtask

    // Driver + monitor for one command; compares against the model.
    task automatic do_txn(input string name, input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        int            lens[$];
        int            run, bad, rsp_c, n;
        logic [1:0]    got_st;
        logic [DW-1:0] got_dat, exp_dat;
        model_txn();
        exp_dat = exp_q.pop_front();
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        cmd_valid = 1'b1;
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(negedge clk_i);
        cmd_valid = 1'b0;
        run = 0; bad = 0; rsp_c = -1; got_st = 'x; got_dat = 'x;
        for (int c = 1; c <= 200; c++) begin
            if (stb_o !== cyc_o || cmd_ready !== 1'b0) bad++;
            if (cyc_o === 1'b1) begin
                run++;
                if (adr_o !== adr || dat_o !== dat || we_o !== we || sel_o !== sel) bad++;
            end else if (run > 0) begin
                lens.push_back(run);
                run = 0;
            end
            if (rsp_valid === 1'b1) begin
                rsp_c = c; got_st = rsp_status; got_dat = rsp_dat;
                break;
            end
            @(negedge clk_i);
        end
        n_cmp++;
        if (rsp_c != exp_rsp_c) begin
            n_bad++;
            $display("FAIL %s latency: got %0d required %0d", name, rsp_c, exp_rsp_c);
        end
        n_cmp++;
        if (got_st !== exp_status) begin
            n_bad++;
            $display("FAIL %s status: got %0d required %0d", name, got_st, exp_status);
        end
        n_cmp++;
        if (got_dat !== exp_dat) begin
            n_bad++;
            $display("FAIL %s rsp_dat: got %h required %h", name, got_dat, exp_dat);
        end
        n_cmp++;
        if (lens.size() != exp_len_q.size()) begin
            n_bad++;
            $display("FAIL %s attempts: got %0d required %0d", name, lens.size(), exp_len_q.size());
        end
        for (int i = 0; i < lens.size() && i < exp_len_q.size(); i++) begin
            n_cmp++;
            if (lens[i] != exp_len_q[i]) begin
                n_bad++;
                $display("FAIL %s attempt%0d_len: got %0d required %0d", name, i, lens[i], exp_len_q[i]);
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s bus_stable: got %0d bad samples required 0", name, bad);
        end
        @(negedge clk_i);
        n_cmp++;
        if ({rsp_valid, cmd_ready, cyc_o, rsp_status, rsp_dat} !== {3'b010, exp_status, exp_dat}) begin
            n_bad++;
            $display("FAIL %s after_rsp: got v=%b rdy=%b cyc=%b st=%0d dat=%h required v=0 rdy=1 cyc=0 st=%0d dat=%h",
                     name, rsp_valid, cmd_ready, cyc_o, rsp_status, rsp_dat, exp_status, exp_dat);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0;
        cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if ({cmd_ready, cyc_o, stb_o, we_o, rsp_valid} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 10000", {cmd_ready, cyc_o, stb_o, we_o, rsp_valid});
        end
        n_cmp++;
        if ({adr_o, dat_o, sel_o, rsp_dat, rsp_status, tgd_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got adr=%h dat=%h sel=%h rdat=%h st=%0d tgd=%0d required all 0",
                     adr_o, dat_o, sel_o, rsp_dat, rsp_status, tgd_o);
        end
        n_cmp++;
        if (state_dbg !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %0d required 0", state_dbg);
        end
        reset = 1'b0;
        last_dat = '0;
        @(negedge clk_i);
    endtask

    task automatic test_write_zero_wait();
        set_att(0, K_ACK, 0);
        rd_data = 32'hDEAD_0001;
        do_txn("write_zero_wait", 1'b1, 32'h10, 32'hA5A5_0F0F, 4'hF);
    endtask

    task automatic test_read_wait();
        set_att(0, K_ACK, 3);
        rd_data = 32'h1234_5678;
        do_txn("read_wait3", 1'b0, 32'h24, 32'h0, 4'h3);
    endtask

    task automatic test_retry();
        set_att(0, K_RTY, 0); set_att(1, K_RTY, 1); set_att(2, K_ACK, 0);
        rd_data = 32'hCAFE_F00D;
        do_txn("retry_then_ack", 1'b1, 32'h40, 32'h0BAD_BEEF, 4'h5);
        set_att(0, K_RTY, 0); set_att(1, K_RTY, 2); set_att(2, K_RTY, 0);
        rd_data = 32'h1111_2222;
        do_txn("retry_exhausted", 1'b0, 32'h44, 32'h0, 4'hF);
    endtask

    task automatic test_timeout_err();
        set_att(0, K_NONE, 0);
        do_txn("timeout", 1'b0, 32'h80, 32'h0, 4'hF);
        set_att(0, K_ACK, TMO);
        rd_data = 32'h5555_AAAA;
        do_txn("ack_at_timeout_edge", 1'b0, 32'h84, 32'h0, 4'hC);
        set_att(0, K_ERR_RTY, 2);
        do_txn("err_beats_rty", 1'b1, 32'h88, 32'h7777_0000, 4'h1);
        set_att(0, K_ALL, 1);
        rd_data = 32'h0F0F_1234;
        do_txn("ack_beats_all", 1'b0, 32'h8C, 32'h0, 4'hF);
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int n_rsp, bad;
        set_att(0, K_ACK, 0);
        rd_data = 32'h3C3C_5A5A;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h100; cmd_dat = '0; cmd_sel = 4'hF;
        n_rsp = 0; bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (acc.size() == 3) cmd_valid = 1'b0;
            if (cmd_valid && cmd_ready === 1'b1) acc.push_back(c);
            if (rsp_valid === 1'b1) begin
                n_rsp++;
                if (rsp_dat !== rd_data || rsp_status !== 2'd0) bad++;
            end
            @(negedge clk_i);
        end
        cmd_valid = 1'b0;
        last_dat = rd_data;
        n_cmp++;
        if (acc.size() != 3) begin
            n_bad++;
            $display("FAIL b2b_accepts: got %0d required 3", acc.size());
        end else begin
            n_cmp++;
            if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
                n_bad++;
                $display("FAIL b2b_interval: got %0d,%0d required 3,3", acc[1] - acc[0], acc[2] - acc[1]);
            end
        end
        n_cmp++;
        if (n_rsp != 3 || bad != 0) begin
            n_bad++;
            $display("FAIL b2b_responses: got %0d (%0d bad) required 3 (0 bad)", n_rsp, bad);
        end
    endtask

    task automatic test_random();
        int r;
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < 8; k++) begin
                r = $urandom_range(0, 9);
                att_kind[k] = (r <= 3) ? K_ACK : (r == 4) ? K_ERR : (r <= 6) ? K_RTY :
                              (r == 7) ? K_ERR_RTY : (r == 8) ? K_ALL : K_NONE;
                att_wait[k] = $urandom_range(0, 6);
            end
            rd_data = $urandom;
            do_txn($sformatf("random%0d", t), 1'($urandom_range(0, 1)), $urandom, $urandom,
                   4'($urandom_range(0, 15)));
        end
    endtask

    task automatic test_reset_mid();
        int seen_rsp, not_ready;
        set_att(0, K_ACK, 4);
        rd_data = 32'h9999_8888;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h200; cmd_dat = 32'h4242_4242; cmd_sel = 4'hF;
        @(negedge clk_i);
        cmd_valid = 1'b0;
        @(negedge clk_i);
        reset = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (cyc_o !== 1'b0 || stb_o !== 1'b0 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_drop: got cyc=%b stb=%b rsp=%b required 0 0 0", cyc_o, stb_o, rsp_valid);
        end
        reset = 1'b0;
        last_dat = '0;
        seen_rsp = 0; not_ready = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid !== 1'b0) seen_rsp++;
            if (cmd_ready !== 1'b1 || cyc_o !== 1'b0) not_ready++;
            @(negedge clk_i);
        end
        n_cmp++;
        if (seen_rsp != 0 || not_ready != 0) begin
            n_bad++;
            $display("FAIL reset_mid_idle: got %0d rsp pulses, %0d non-idle cycles required 0,0", seen_rsp, not_ready);
        end
        n_cmp++;
        if (rsp_dat !== '0 || rsp_status !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_mid_rsp: got dat=%h st=%0d required 0 0", rsp_dat, rsp_status);
        end
        set_att(0, K_ACK, 1);
        rd_data = 32'h7E57_0001;
        do_txn("after_reset", 1'b0, 32'h204, 32'h0, 4'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 8; k++) begin
            att_kind[k] = K_NONE;
            att_wait[k] = 0;
        end
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_retry();
        test_timeout_err();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wishbone_cmd_master.md
Name: wishbone_cmd_master

Overview:
- Wishbone classic single-transfer bus master driven by a simple valid/ready command port.
- Lets a controller (sequencer, debug bridge, audio control FSM) issue individual reads and writes to the team's Wishbone slaves.
- Handles slave retry with a bounded retry count and a per-attempt timeout.
- Returns a one-cycle response carrying read data and a status code.

Parameters:
- ADDR_WIDTH, 32, width of adr_o / cmd_adr
- DATA_WIDTH, 32, width of data buses
- SELECT_WIDTH, 4, width of sel_o / cmd_sel
- MAX_RETRIES, 3, number of re-issues allowed after rty_i (0 = no re-issue)
- TIMEOUT, 255, max wait cycles per attempt before abort (0 = timeout disabled); counter width sized from TIMEOUT

Ports:
- clk_i  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
- cmd_we  input  1  1 = write, 0 = read
- cmd_adr  input  ADDR_WIDTH  target address
- cmd_dat  input  DATA_WIDTH  write data
- cmd_sel  input  SELECT_WIDTH  byte/granule selects
- rsp_valid  output  1  one-cycle response pulse
- rsp_dat  output  DATA_WIDTH  read data (captured dat_i); holds until next response
- rsp_status  output  2  0 = OK, 1 = ERR, 2 = TIMEOUT, 3 = RETRY_EXHAUSTED
- cyc_o, stb_o, we_o  output  1 each  Wishbone master controls
- adr_o  output  ADDR_WIDTH  Wishbone address
- dat_o  output  DATA_WIDTH  Wishbone write data
- sel_o  output  SELECT_WIDTH  Wishbone selects
- tgd_o  output  2  data tag, tied 2'h0
- dat_i  input  DATA_WIDTH  Wishbone read data
- ack_i, err_i, rty_i  input  1 each  Wishbone terminations
- tgd_i  input  2  ignored

Behaviour:
- All state changes occur on the rising edge of clk_i.
- Reset values:
  - state IDLE; cmd_ready = 1.
  - cyc_o, stb_o, we_o, rsp_valid = 0.
  - adr_o, dat_o, sel_o, rsp_dat = 0; rsp_status = 0.
  - Retry and timeout counters = 0.
- Reset mid-transaction: cyc_o/stb_o drop on the next edge and no rsp_valid is produced for the aborted command.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch we/adr/dat/sel into the bus output registers, clear retry_cnt and timer, go to BUS.
- BUS:
  - cyc_o = stb_o = 1; cmd_ready = 0; bus outputs stable for the whole attempt.
  - Terminations are sampled each edge with priority ack_i > err_i > rty_i (simultaneous assertion is a slave violation but has this defined outcome).
  - ack_i: rsp_dat <= dat_i (writes also capture), status OK, go to DONE.
  - err_i: status ERR, go to DONE; rsp_dat unchanged.
  - rty_i with retry_cnt == MAX_RETRIES: status RETRY_EXHAUSTED, go to DONE.
  - rty_i otherwise: retry_cnt++, go to BACKOFF.
  - No termination: timer++. When TIMEOUT != 0 and timer == TIMEOUT at the edge, status TIMEOUT, go to DONE.
- BACKOFF:
  - cyc_o = stb_o = 0 for exactly one cycle.
  - Clear timer, return to BUS with the same address/data.
- DONE:
  - rsp_valid = 1 for one cycle; cyc_o = stb_o = 0; cmd_ready = 0.
  - Next state IDLE.
- Latency: the command is accepted at edge 0.
  - cyc_o is high in cycle 1.
  - A zero-wait (combinational) ack in cycle 1 gives rsp_valid in cycle 2 and cmd_ready in cycle 3.
  - Minimum issue interval is 3 cycles.
- Bus idle guarantee: cyc_o is never high outside BUS; stb_o == cyc_o always.
- rsp_dat and rsp_status hold their values between responses.
- TIMEOUT attempt length: an attempt with no termination lasts TIMEOUT+1 cycles of cyc_o high.

Test Plan:
- Write with a zero-wait slave model: cmd_we=1, adr=0x10, dat=0xA5A5_0F0F, sel=4'hF.
  - Expect cyc_o high for exactly 1 cycle with those values on the bus.
  - rsp_valid one cycle later, status 0; cmd_ready back one cycle after that.
- Read with 3 wait states: slave drives dat_i=0x1234_5678 with ack in the 4th bus cycle.
  - Expect cyc_o high for 4 cycles, rsp_dat=0x1234_5678, status 0.
- Retry handling: slave asserts rty_i twice, then ack.
  - Expect two one-cycle cyc_o gaps with identical adr/dat on each attempt, then status 0.
  - With MAX_RETRIES=1 and rty_i on every attempt: exactly 2 attempts, then status 3.
- Timeout and error:
  - TIMEOUT=5 with an unresponsive slave: cyc_o high for 6 cycles, status 2.
  - err_i asserted together with rty_i: status 1 (err wins), no retry.
- Back-to-back and reset:
  - cmd_valid held high for 3 commands: each is accepted only when cmd_ready=1, at intervals of 3 cycles.
  - reset asserted in the 2nd wait cycle: cyc_o=0 next cycle, no rsp_valid, cmd_ready=1 after reset release.
